rf_wb_arbiter: RTL

- Shares the register file's single write port between two writeback requesters: ALU and load/store unit (LSU).
- Each requester gets a one-entry holding buffer with a valid/ready handshake.
- Grants are oldest-first, with a round-robin tie-break; writes to x0 are suppressed.
- Exports a pending-write mask for the decode stage's hazard check; drives rd/rd_data/rd_write of the register file directly.

---
 rtl/rf_wb_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Two writeback requesters (ALU and LSU) share the register file's single
// write port. Each requester owns a one-entry holding buffer. The older
// buffered entry is granted first. Entries captured on the same edge are
// resolved by a round-robin pointer. Writes to x0 retire without writing.
// busy_mask tells decode which registers still have a buffered write pending.
module rf_wb_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic [31:0]     rf_rd,
  output logic [XLEN-1:0] rf_rd_data,
  output logic            rf_rd_write,
  output logic            alu_done,
  output logic            lsu_done,
  output logic [31:0]     busy_mask
);

  // ALU holding buffer
  logic            alu_full;
  logic [4:0]      alu_rd_q;
  logic [XLEN-1:0] alu_data_q;
  logic            alu_older;

  // LSU holding buffer
  logic            lsu_full;
  logic [4:0]      lsu_rd_q;
  logic [XLEN-1:0] lsu_data_q;
  logic            lsu_older;

  // Round-robin pointer used only when both entries have the same age:
  // 0 favours the ALU, 1 favours the LSU.
  logic            rr_lsu;

  logic            grant_alu;
  logic            grant_lsu;
  logic            tie_grant;
  logic            alu_accept;
  logic            lsu_accept;

  // Grant selection looks only at buffered state, never at the valid inputs
  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    tie_grant = 1'b0;
    if (alu_full && lsu_full) begin
      if (alu_older != lsu_older) begin
        grant_alu = alu_older;
        grant_lsu = lsu_older;
      end else begin
        tie_grant = 1'b1;
        grant_alu = !rr_lsu;
        grant_lsu = rr_lsu;
      end
    end else begin
      grant_alu = alu_full;
      grant_lsu = lsu_full;
    end
  end

  // A buffer that is retiring this edge can take a new entry at the same time
  assign alu_ready  = !alu_full || grant_alu;
  assign lsu_ready  = !lsu_full || grant_lsu;
  assign alu_accept = alu_valid && alu_ready;
  assign lsu_accept = lsu_valid && lsu_ready;

  // Drive the register-file write port from whichever buffer holds the grant
  always_comb begin
    rf_rd       = '0;
    rf_rd_data  = '0;
    rf_rd_write = 1'b0;
    if (grant_alu) begin
      rf_rd       = {27'b0, alu_rd_q};
      rf_rd_data  = alu_data_q;
      rf_rd_write = |alu_rd_q;
    end else if (grant_lsu) begin
      rf_rd       = {27'b0, lsu_rd_q};
      rf_rd_data  = lsu_data_q;
      rf_rd_write = |lsu_rd_q;
    end
  end

  // Pending-write mask for the hazard check; x0 never counts as pending
  always_comb begin
    busy_mask = '0;
    if (alu_full) begin
      busy_mask[alu_rd_q] = 1'b1;
    end
    if (lsu_full) begin
      busy_mask[lsu_rd_q] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

  // ALU buffer: capture, retire, and become "older" when the LSU captures behind it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_full   <= 1'b0;
      alu_rd_q   <= '0;
      alu_data_q <= '0;
      alu_older  <= 1'b0;
    end else if (alu_accept) begin
      alu_full   <= 1'b1;
      alu_rd_q   <= alu_rd;
      alu_data_q <= alu_data;
      alu_older  <= 1'b0;
    end else if (grant_alu) begin
      alu_full   <= 1'b0;
      alu_older  <= 1'b0;
    end else if (alu_full && lsu_accept) begin
      alu_older  <= 1'b1;
    end
  end

  // LSU buffer: capture, retire, and become "older" when the ALU captures behind it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lsu_full   <= 1'b0;
      lsu_rd_q   <= '0;
      lsu_data_q <= '0;
      lsu_older  <= 1'b0;
    end else if (lsu_accept) begin
      lsu_full   <= 1'b1;
      lsu_rd_q   <= lsu_rd;
      lsu_data_q <= lsu_data;
      lsu_older  <= 1'b0;
    end else if (grant_lsu) begin
      lsu_full   <= 1'b0;
      lsu_older  <= 1'b0;
    end else if (lsu_full && alu_accept) begin
      lsu_older  <= 1'b1;
    end
  end

  // Flip the round-robin pointer each time it breaks a same-age tie
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_lsu <= 1'b0;
    end else if (tie_grant) begin
      rr_lsu <= !rr_lsu;
    end
  end

  // Registered retire pulses, high for the cycle after the entry leaves its buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_done <= 1'b0;
      lsu_done <= 1'b0;
    end else begin
      alu_done <= grant_alu;
      lsu_done <= grant_lsu;
    end
  end

endmodule
